// File: rtl/pit_channel.sv
// pit_channel: one 8253-style interval timer channel (binary modes 0, 2, 3) counting on iClkEn ticks.
// Define PIT_LATCH_EN to enable the RW=00 counter-latch command.
module pit_channel #(
    parameter bit RESET_OUT = 1'b1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iClkEn,
    input  logic       iGate,
    input  logic       iCtrlWr,
    input  logic       iWr,
    input  logic       iRd,
    input  logic [7:0] iData,
    output logic [7:0] oData,
    output logic       oOut
);
    typedef enum logic [1:0] {
        MODE_INT    = 2'd0,
        MODE_RATE   = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_OFF    = 2'd3
    } opMode_t;

    logic [15:0] countReg, countNext;
    logic [15:0] reloadReg, reloadNext;
    logic [15:0] latchReg, latchNext;
    logic [7:0]  lsbReg, lsbNext;
    logic [7:0]  dataReg, dataNext;
    logic [2:0]  modeReg, modeNext;
    logic [1:0]  rwReg, rwNext;
    logic        wrPtrReg, wrPtrNext;
    logic        rdPtrReg, rdPtrNext;
    logic        armedReg, armedNext;
    logic        loadPendReg, loadPendNext;
    logic        latchedReg, latchedNext;
    logic        gatePrevReg;
    logic        outReg, outNext;

    opMode_t     opMode;
    logic [15:0] sqLow, sqHigh, rdSrc, wrVal;
    logic        tickEn, gateRise, wrDone;

    always_comb begin
        countNext    = countReg;
        reloadNext   = reloadReg;
        latchNext    = latchReg;
        lsbNext      = lsbReg;
        dataNext     = dataReg;
        modeNext     = modeReg;
        rwNext       = rwReg;
        wrPtrNext    = wrPtrReg;
        rdPtrNext    = rdPtrReg;
        armedNext    = armedReg;
        loadPendNext = loadPendReg;
        latchedNext  = latchedReg;
        outNext      = outReg;
        wrVal        = 16'd0;
        wrDone       = 1'b0;

        if (modeReg == 3'd0)
            opMode = MODE_INT;
        else if (modeReg[1])
            opMode = modeReg[0] ? MODE_SQUARE : MODE_RATE;
        else
            opMode = MODE_OFF;

        // Square wave halves: odd N splits into N+1 (high) and N-1 (low).
        sqLow    = {reloadReg[15:1], 1'b0};
        sqHigh   = sqLow + {14'd0, reloadReg[0], 1'b0};
        gateRise = iGate && !gatePrevReg;
        tickEn   = iClkEn && armedReg && !loadPendReg && iGate;
        rdSrc    = latchedReg ? latchReg : countReg;

        if (opMode != MODE_OFF && iClkEn && loadPendReg) begin
            countNext    = (opMode == MODE_SQUARE) ? (outReg ? sqHigh : sqLow) : reloadReg;
            armedNext    = 1'b1;
            loadPendNext = 1'b0;
        end else if (tickEn) begin
            case (opMode)
                MODE_INT: begin
                    countNext = countReg - 16'd1;
                    if (countReg == 16'd1)
                        outNext = 1'b1;
                end
                MODE_RATE: begin
                    if (countReg == 16'd1) begin
                        countNext = reloadReg;
                        outNext   = 1'b1;
                    end else begin
                        countNext = countReg - 16'd1;
                        if (countReg == 16'd2)
                            outNext = 1'b0;
                    end
                end
                MODE_SQUARE: begin
                    if (countReg == 16'd2) begin
                        // N=1 never toggles, so the output stays high.
                        if (reloadReg != 16'd1) begin
                            outNext   = !outReg;
                            countNext = outReg ? sqLow : sqHigh;
                        end else begin
                            countNext = sqHigh;
                        end
                    end else begin
                        countNext = countReg - 16'd2;
                    end
                end
                default: ;
            endcase
        end

        if ((opMode == MODE_RATE || opMode == MODE_SQUARE) && gateRise && armedReg)
            loadPendNext = 1'b1;
        if ((opMode == MODE_SQUARE && !iGate) || opMode == MODE_OFF)
            outNext = 1'b1;

        if (iRd) begin
            case (rwReg)
                2'b01: begin
                    dataNext    = rdSrc[7:0];
                    latchedNext = 1'b0;
                end
                2'b10: begin
                    dataNext    = rdSrc[15:8];
                    latchedNext = 1'b0;
                end
                default: begin
                    dataNext  = rdPtrReg ? rdSrc[15:8] : rdSrc[7:0];
                    rdPtrNext = !rdPtrReg;
                    if (rdPtrReg)
                        latchedNext = 1'b0;
                end
            endcase
        end

        // A control write overrides tick, read-pointer and data-write effects in the same cycle.
        if (iCtrlWr) begin
            if (iData[5:4] != 2'b00) begin
                modeNext     = iData[3:1];
                rwNext       = iData[5:4];
                wrPtrNext    = 1'b0;
                rdPtrNext    = 1'b0;
                armedNext    = 1'b0;
                loadPendNext = 1'b0;
                latchedNext  = 1'b0;
                outNext      = (iData[3:1] != 3'd0);
            end
`ifdef PIT_LATCH_EN
            else if (!latchedReg) begin
                latchNext   = countReg;
                latchedNext = 1'b1;
            end
`endif
        end else if (iWr) begin
            case (rwReg)
                2'b01: begin
                    wrVal  = {8'h00, iData};
                    wrDone = 1'b1;
                end
                2'b10: begin
                    wrVal  = {iData, 8'h00};
                    wrDone = 1'b1;
                end
                default: begin
                    if (!wrPtrReg) begin
                        lsbNext   = iData;
                        wrPtrNext = 1'b1;
                        if (modeReg == 3'd0)
                            armedNext = 1'b0;
                    end else begin
                        wrVal     = {iData, lsbReg};
                        wrDone    = 1'b1;
                        wrPtrNext = 1'b0;
                    end
                end
            endcase
            if (wrDone) begin
                reloadNext   = wrVal;
                loadPendNext = 1'b1;
                if (modeReg == 3'd0)
                    outNext = 1'b0;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            countReg    <= 16'd0;
            reloadReg   <= 16'd0;
            latchReg    <= 16'd0;
            lsbReg      <= 8'd0;
            dataReg     <= 8'd0;
            modeReg     <= 3'd0;
            rwReg       <= 2'b11;
            wrPtrReg    <= 1'b0;
            rdPtrReg    <= 1'b0;
            armedReg    <= 1'b0;
            loadPendReg <= 1'b0;
            latchedReg  <= 1'b0;
            gatePrevReg <= 1'b0;
            outReg      <= RESET_OUT;
        end else begin
            countReg    <= countNext;
            reloadReg   <= reloadNext;
            latchReg    <= latchNext;
            lsbReg      <= lsbNext;
            dataReg     <= dataNext;
            modeReg     <= modeNext;
            rwReg       <= rwNext;
            wrPtrReg    <= wrPtrNext;
            rdPtrReg    <= rdPtrNext;
            armedReg    <= armedNext;
            loadPendReg <= loadPendNext;
            latchedReg  <= latchedNext;
            gatePrevReg <= iGate;
            outReg      <= outNext;
        end
    end

    assign oData = dataReg;
    assign oOut  = outReg;
endmodule
